// File: rtl/sample_serializer.sv
// Splits right-justified audio samples into an LSB-first byte stream.
// An active shift register plus a one-entry pending buffer keep the output gap-free.
module sample_serializer (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] sample_in,
    input  logic [3:0]  sample_size,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        byte_last,
    output logic        size_err
);

    localparam logic [3:0] S_8BIT  = 4'd0;
    localparam logic [3:0] S_12BIT = 4'd1;
    localparam logic [3:0] S_16BIT = 4'd3;
    localparam logic [3:0] S_24BIT = 4'd4;
    localparam logic [3:0] S_32BIT = 4'd5;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t      r_state;
    logic [31:0] r_actData;
    logic [2:0]  r_actLeft;
    logic        r_pendValid;
    logic [31:0] r_pendData;
    logic [2:0]  r_pendLeft;
    logic        r_sizeErr;

    state_t      w_nextState;
    logic [31:0] w_nextActData;
    logic [2:0]  w_nextActLeft;
    logic        w_nextPendValid;
    logic [31:0] w_nextPendData;
    logic [2:0]  w_nextPendLeft;
    logic        w_nextSizeErr;

    logic [31:0] w_mask;
    logic [2:0]  w_count;
    logic        w_sizeOk;
    logic [31:0] w_masked;
    logic        w_accept;
    logic        w_acceptGood;
    logic        w_transfer;
    logic        w_lastXfer;

    // Size code decode: byte count and mask; unsupported codes flag w_sizeOk low.
    always_comb begin
        w_mask   = 32'h0000_0000;
        w_count  = 3'd0;
        w_sizeOk = 1'b0;
        case (sample_size)
            S_8BIT:  begin w_mask = 32'h0000_00FF; w_count = 3'd1; w_sizeOk = 1'b1; end
            S_12BIT: begin w_mask = 32'h0000_0FFF; w_count = 3'd2; w_sizeOk = 1'b1; end
            S_16BIT: begin w_mask = 32'h0000_FFFF; w_count = 3'd2; w_sizeOk = 1'b1; end
            S_24BIT: begin w_mask = 32'h00FF_FFFF; w_count = 3'd3; w_sizeOk = 1'b1; end
            S_32BIT: begin w_mask = 32'hFFFF_FFFF; w_count = 3'd4; w_sizeOk = 1'b1; end
            default: begin w_mask = 32'h0000_0000; w_count = 3'd0; w_sizeOk = 1'b0; end
        endcase
    end

    assign w_masked     = sample_in & w_mask;
    assign sample_ready = !rst && !r_pendValid;
    assign w_accept     = sample_valid && sample_ready;
    assign w_acceptGood = w_accept && w_sizeOk;
    assign w_transfer   = (r_state == SEND) && byte_ready;
    assign w_lastXfer   = w_transfer && (r_actLeft == 3'd1);

    assign byte_out   = r_actData[7:0];
    assign byte_valid = (r_state == SEND);
    assign byte_last  = (r_state == SEND) && (r_actLeft == 3'd1);
    assign size_err   = r_sizeErr;

    // Next-state logic; a sample finishing this cycle is replaced by pending first, then by a new accept.
    always_comb begin
        w_nextState     = r_state;
        w_nextActData   = r_actData;
        w_nextActLeft   = r_actLeft;
        w_nextPendValid = r_pendValid;
        w_nextPendData  = r_pendData;
        w_nextPendLeft  = r_pendLeft;
        w_nextSizeErr   = w_accept && !w_sizeOk;

        case (r_state)
            IDLE: begin
                if (w_acceptGood) begin
                    w_nextState   = SEND;
                    w_nextActData = w_masked;
                    w_nextActLeft = w_count;
                end
            end
            SEND: begin
                if (w_transfer) begin
                    if (r_actLeft > 3'd1) begin
                        w_nextActData = {8'h00, r_actData[31:8]};
                        w_nextActLeft = r_actLeft - 3'd1;
                    end else if (r_pendValid) begin
                        w_nextActData   = r_pendData;
                        w_nextActLeft   = r_pendLeft;
                        w_nextPendValid = 1'b0;
                    end else if (w_acceptGood) begin
                        w_nextActData = w_masked;
                        w_nextActLeft = w_count;
                    end else begin
                        w_nextState = IDLE;
                    end
                end
                if (w_acceptGood && !w_lastXfer) begin
                    w_nextPendValid = 1'b1;
                    w_nextPendData  = w_masked;
                    w_nextPendLeft  = w_count;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_actData   <= 32'h0000_0000;
            r_actLeft   <= 3'd0;
            r_pendValid <= 1'b0;
            r_pendData  <= 32'h0000_0000;
            r_pendLeft  <= 3'd0;
            r_sizeErr   <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_actData   <= w_nextActData;
            r_actLeft   <= w_nextActLeft;
            r_pendValid <= w_nextPendValid;
            r_pendData  <= w_nextPendData;
            r_pendLeft  <= w_nextPendLeft;
            r_sizeErr   <= w_nextSizeErr;
        end
    end

endmodule

// File: tb/tb_sample_serializer.sv
// Scoreboard bench for sample_serializer: the driver pushes expected bytes on acceptance,
// a negedge monitor pops and compares them whenever the DUT presents a byte.
module tb_sample_serializer;

    logic        clk;
    logic        rst;
    logic [31:0] sample_in;
    logic [3:0]  sample_size;
    logic        sample_valid;
    logic        sample_ready;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready;
    logic        byte_last;
    logic        size_err;

    logic [8:0]  expQ[$];
    int          checks = 0;
    int          errors = 0;
    bit          errPending = 0;
    bit          rstPrev = 0;
    int          readyMode = 0;

    sample_serializer dut (
        .clk          (clk),
        .rst          (rst),
        .sample_in    (sample_in),
        .sample_size  (sample_size),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .byte_out     (byte_out),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .byte_last    (byte_last),
        .size_err     (size_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference split: byte count from the size table, then plain shifts of the masked word.
    task automatic pushExpected(input logic [31:0] data, input logic [3:0] size);
        int n;
        logic [31:0] masked;
        logic [31:0] word;
        case (size)
            4'd0: begin n = 1; masked = data % 32'h100; end
            4'd1: begin n = 2; masked = data % 32'h1000; end
            4'd3: begin n = 2; masked = data % 32'h10000; end
            4'd4: begin n = 3; masked = data % 32'h1000000; end
            4'd5: begin n = 4; masked = data; end
            default: begin n = 0; masked = 0; end
        endcase
        if (n == 0) errPending = 1'b1;
        for (int k = 0; k < n; k++) begin
            word = masked >> (8 * k);
            expQ.push_back({(k == n - 1), word[7:0]});
        end
    endtask

    function automatic int outstanding();
        int c = 0;
        foreach (expQ[i]) if (expQ[i][8]) c++;
        return c;
    endfunction

    always @(posedge clk) begin
        #1;
        case (readyMode)
            0:       byte_ready = 1'b0;
            1:       byte_ready = 1'b1;
            default: byte_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: sampling at negedge sees state settled after the previous posedge and the transfer about to happen.
    always @(negedge clk) begin
        if (rst) begin
            checkOutput("ready_in_reset", 32'(sample_ready), 32'd0);
            if (rstPrev) begin
                checkOutput("reset_valid", 32'(byte_valid), 32'd0);
                checkOutput("reset_last", 32'(byte_last), 32'd0);
                checkOutput("reset_err", 32'(size_err), 32'd0);
                checkOutput("reset_byte", 32'(byte_out), 32'd0);
            end
            rstPrev = 1'b1;
        end else begin
            rstPrev = 1'b0;
            checkOutput("sample_ready", 32'(sample_ready), 32'(outstanding() < 2));
            checkOutput("byte_valid", 32'(byte_valid), 32'(expQ.size() != 0));
            if (byte_valid && expQ.size() != 0) begin
                checkOutput("byte_out", 32'(byte_out), 32'(expQ[0][7:0]));
                checkOutput("byte_last", 32'(byte_last), 32'(expQ[0][8]));
                if (byte_ready) void'(expQ.pop_front());
            end else begin
                checkOutput("byte_last_idle", 32'(byte_last), 32'd0);
            end
            checkOutput("size_err", 32'(size_err), 32'(errPending));
            errPending = 1'b0;
        end
    end

    task automatic applyStimulus(input logic [31:0] data, input logic [3:0] size);
        int waited = 0;
        sample_in    = data;
        sample_size  = size;
        sample_valid = 1'b1;
        @(negedge clk);
        while (!sample_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!sample_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: sample_ready 0 required 1");
            sample_valid = 1'b0;
            return;
        end
        @(posedge clk);
        pushExpected(data, size);
        #1;
        sample_valid = 1'b0;
        sample_in    = $urandom;
        sample_size  = 4'($urandom);
    endtask

    task automatic waitDrain();
        int w = 0;
        while (expQ.size() != 0 && w < 1000) begin
            @(posedge clk);
            w++;
        end
        @(posedge clk);
        #1;
        if (expQ.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: %0d bytes left required 0", expQ.size());
            expQ.delete();
        end
    endtask

    initial begin
        logic [3:0] sizes[5];
        sizes = '{4'd0, 4'd1, 4'd3, 4'd4, 4'd5};
        sample_valid = 1'b0;
        sample_in    = 32'h0;
        sample_size  = 4'h0;
        byte_ready   = 1'b0;
        rst          = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        readyMode = 1;
        @(posedge clk);
        #1;

        applyStimulus(32'hDEADBEEF, 4'd3);
        waitDrain();

        applyStimulus(32'h00123456, 4'd4);
        applyStimulus(32'hA1B2C3D4, 4'd5);
        waitDrain();

        applyStimulus(32'hFFFFFABC, 4'd1);
        applyStimulus(32'h12345678, 4'd0);
        waitDrain();

        applyStimulus(32'h11223344, 4'd2);
        applyStimulus(32'h55667788, 4'd7);
        applyStimulus(32'h0000BEEF, 4'd3);
        waitDrain();

        readyMode = 2;
        for (int i = 0; i < 100; i++) begin
            applyStimulus($urandom, sizes[$urandom_range(0, 4)]);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        readyMode = 1;
        waitDrain();

        // Reset with a 32-bit sample half sent and another waiting in pending.
        readyMode = 0;
        @(posedge clk);
        #1;
        applyStimulus(32'h89ABCDEF, 4'd5);
        applyStimulus(32'h00765432, 4'd4);
        readyMode = 1;
        @(posedge clk);
        @(posedge clk);
        readyMode = 0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        expQ.delete();
        errPending = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        readyMode = 1;
        @(posedge clk);
        #1;
        applyStimulus(32'hCAFEF00D, 4'd4);
        waitDrain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
